// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: shift-register scoreboard of in-flight destinations plus a
// saturating stall counter. Define HAZARD_FORWARDING_EN to stall only on load-use in entry 0.

module hazard_sb_entry (
    input  logic       v,
    input  logic [3:0] dest,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    output logic       hit1,
    output logic       hit2
);
    assign hit1 = v && (dest == src1);
    assign hit2 = v && (dest == src2);
endmodule

module hazard_scoreboard #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [3:0]       id_dest,
    input  logic             freeze,
    input  logic             flush,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_count
);
    logic [DEPTH-1:0]      v;
    logic [DEPTH-1:0]      ld;
    logic [DEPTH-1:0][3:0] dest;
    logic [DEPTH-1:0]      hit1;
    logic [DEPTH-1:0]      hit2;
    logic [DEPTH-1:0]      qual;
    logic                  m1;
    logic                  m2;
    logic                  issue;

    hazard_sb_entry u_ent [DEPTH-1:0] (
        .v    (v),
        .dest (dest),
        .src1 (src1),
        .src2 (src2),
        .hit1 (hit1),
        .hit2 (hit2)
    );

`ifdef HAZARD_FORWARDING_EN
    // ALU results are forwarded; only a load still in EXE cannot be bypassed.
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_qual
            if (g == 0) begin : g_exe
                assign qual[g] = ld[g];
            end else begin : g_late
                assign qual[g] = 1'b0;
            end
        end
    endgenerate
`else
    logic unused_ld;
    assign unused_ld = ^ld;
    assign qual      = '1;
`endif

    assign m1     = id_valid && |(hit1 & qual);
    assign m2     = id_valid && two_src && |(hit2 & qual);
    assign hazard = m1 || m2;
    assign issue  = id_valid && id_wb_en && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v           <= '0;
            ld          <= '0;
            dest        <= '0;
            stall_count <= '0;
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                v[i]    <= v[i-1];
                ld[i]   <= ld[i-1];
                dest[i] <= dest[i-1];
            end
            v[0]    <= issue;
            ld[0]   <= issue && id_mem_read;
            dest[0] <= issue ? id_dest : 4'd0;
            if (hazard && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule
